// File: rtl/adc_pkt_pkg.sv
// Shared types and helpers for the ADC sample packetizer.
// Frame state encoding, default sync byte and frame length.
package adc_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEQ,
        ST_HI,
        ST_LO,
        ST_CHK
    } pkt_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic int unsigned frame_len(input int unsigned n);
        return 3 + 2 * n;
    endfunction

endpackage

// File: rtl/sample_decimator.sv
// Keeps one of every DECIM valid samples while capture is enabled.
// The counter is held at zero whenever capture is disabled.
module sample_decimator #(
    parameter int unsigned DECIM = 2000
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    input  logic enable_i,
    output logic accept_o
);

    logic [15:0] decim_cnt;
    logic        at_last;

    assign at_last  = decim_cnt == 16'(DECIM - 1);
    assign accept_o = enable_i && valid_i && at_last;

    // Count valid samples, wrapping on the accepted one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decim_cnt <= '0;
        end else if (!enable_i) begin
            decim_cnt <= '0;
        end else if (valid_i) begin
            decim_cnt <= at_last ? '0 : decim_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/adc_sample_packetizer.sv
// Frames decimated ADC samples into sync/seq/payload/checksum packets.
// Ping-pong buffers let one frame fill while the other is written out.
module adc_sample_packetizer
    import adc_pkt_pkg::*;
#(
    parameter int unsigned DECIM             = 2000,
    parameter int unsigned SAMPLES_PER_FRAME = 4,
    parameter logic [7:0]  SYNC_BYTE         = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sample_i,
    input  logic        valid_i,
    input  logic        enable_i,
    input  logic        clear_i,
    input  logic        fifo_full_i,
    output logic [7:0]  data_o,
    output logic        wr_en_o,
    output logic        busy_o,
    output logic        overflow_o,
    output logic [15:0] drop_count_o
);

    localparam logic [4:0] SPF      = 5'(SAMPLES_PER_FRAME);
    localparam logic [3:0] LAST_IDX = 4'(SAMPLES_PER_FRAME - 1);

    pkt_state_t  state, state_n;
    logic [11:0] mem [2][16];
    logic        col_sel;
    logic [4:0]  collect_cnt;
    logic [3:0]  idx;
    logic [7:0]  seq;
    logic [7:0]  chk;
    logic [11:0] tx_sample;
    logic        accept;
    logic        full;
    logic        swap;
    logic        drop;

    sample_decimator #(
        .DECIM(DECIM)
    ) u_decim (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .enable_i (enable_i),
        .accept_o (accept)
    );

    assign full      = collect_cnt == SPF;
    assign swap      = (state == ST_IDLE) && full;
    assign drop      = accept && full && (state != ST_IDLE);
    assign tx_sample = mem[~col_sel][idx];
    assign wr_en_o   = (state != ST_IDLE) && !fifo_full_i;
    assign busy_o    = state != ST_IDLE;

    // Select the outgoing byte and advance only when it is written.
    always_comb begin
        state_n = state;
        data_o  = '0;
        unique case (state)
            ST_IDLE: begin
                if (full) state_n = ST_SYNC;
            end
            ST_SYNC: begin
                data_o = SYNC_BYTE;
                if (wr_en_o) state_n = ST_SEQ;
            end
            ST_SEQ: begin
                data_o = seq;
                if (wr_en_o) state_n = ST_HI;
            end
            ST_HI: begin
                data_o = {4'h0, tx_sample[11:8]};
                if (wr_en_o) state_n = ST_LO;
            end
            ST_LO: begin
                data_o = tx_sample[7:0];
                if (wr_en_o) state_n = (idx < LAST_IDX) ? ST_HI : ST_CHK;
            end
            ST_CHK: begin
                data_o = chk;
                if (wr_en_o) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Sample index, running checksum and sequence number of the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            chk <= '0;
            seq <= '0;
        end else if (swap) begin
            idx <= '0;
            chk <= '0;
        end else if (wr_en_o) begin
            if (state == ST_SEQ || state == ST_HI || state == ST_LO)
                chk <= chk ^ data_o;
            if (state == ST_LO)
                idx <= idx + 4'd1;
            if (state == ST_CHK)
                seq <= seq + 8'd1;
        end
    end

    // Collect buffer fill, ping-pong swap and discard on disable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_sel     <= 1'b0;
            collect_cnt <= '0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 16; i++)
                    mem[b][i] <= '0;
        end else if (swap) begin
            col_sel     <= ~col_sel;
            collect_cnt <= accept ? 5'd1 : 5'd0;
            if (accept) mem[~col_sel][0] <= sample_i;
        end else if (!enable_i && !full) begin
            collect_cnt <= '0;
        end else if (accept && !full) begin
            mem[col_sel][collect_cnt[3:0]] <= sample_i;
            collect_cnt <= collect_cnt + 5'd1;
        end
    end

    // Dropped-sample statistics; clear wins over a same-cycle drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else if (clear_i) begin
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_count_o != 16'hFFFF)
                drop_count_o <= drop_count_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_adc_sample_packetizer.sv
// Bench for adc_sample_packetizer: directed steps plus random traffic
// compared every cycle against a queue-based frame model.
module tb_adc_sample_packetizer;
    import adc_pkt_pkg::*;

    localparam int DECIM = 4;
    localparam int SPF   = 2;
    localparam int FLEN  = int'(frame_len(SPF));

    logic        clk;
    logic        rst;
    logic [11:0] sample_i;
    logic        valid_i;
    logic        enable_i;
    logic        clear_i;
    logic        fifo_full_i;
    logic [7:0]  data_o;
    logic        wr_en_o;
    logic        busy_o;
    logic        overflow_o;
    logic [15:0] drop_count_o;

    adc_sample_packetizer #(
        .DECIM             (DECIM),
        .SAMPLES_PER_FRAME (SPF),
        .SYNC_BYTE         (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_i     (sample_i),
        .valid_i      (valid_i),
        .enable_i     (enable_i),
        .clear_i      (clear_i),
        .fifo_full_i  (fifo_full_i),
        .data_o       (data_o),
        .wr_en_o      (wr_en_o),
        .busy_o       (busy_o),
        .overflow_o   (overflow_o),
        .drop_count_o (drop_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_dec;
    logic [11:0] m_coll[$];
    logic [7:0]  m_tx[$];
    logic [7:0]  m_seq;
    int          m_drops;
    logic        m_ovf;

    // Observed write stream
    logic [7:0] wlog[$];
    logic [7:0] seq_log[$];
    int         wpos;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dec = 0;
        m_coll.delete();
        m_tx.delete();
        m_seq = 8'h00;
        m_drops = 0;
        m_ovf = 1'b0;
    endtask

    task automatic build_frame();
        logic [7:0] c;
        m_tx.push_back(8'hA5);
        m_tx.push_back(m_seq);
        c = m_seq;
        foreach (m_coll[i]) begin
            m_tx.push_back({4'h0, m_coll[i][11:8]});
            m_tx.push_back(m_coll[i][7:0]);
            c = c ^ {4'h0, m_coll[i][11:8]} ^ m_coll[i][7:0];
        end
        m_tx.push_back(c);
        m_seq = m_seq + 8'd1;
        m_coll.delete();
    endtask

    task automatic step(input logic v, input logic [11:0] s,
                        input logic en, input logic clr, input logic ff);
        logic acc, was_idle, drp;
        valid_i     = v;
        sample_i    = s;
        enable_i    = en;
        clear_i     = clr;
        fifo_full_i = ff;
        @(negedge clk);
        check("wr_en", 32'(wr_en_o), 32'(m_tx.size() > 0 && !ff));
        check("data", 32'(data_o), 32'(m_tx.size() > 0 ? m_tx[0] : 8'h00));
        check("busy", 32'(busy_o), 32'(m_tx.size() > 0));
        check("overflow", 32'(overflow_o), 32'(m_ovf));
        check("drop_count", 32'(drop_count_o), 32'(m_drops));
        if (wr_en_o === 1'b1) begin
            wlog.push_back(data_o);
            if (wpos == 1) seq_log.push_back(data_o);
            wpos = (wpos + 1 == FLEN) ? 0 : wpos + 1;
        end
        @(posedge clk);
        acc = 1'b0;
        drp = 1'b0;
        if (!en) begin
            m_dec = 0;
            if (m_coll.size() < SPF) m_coll.delete();
        end else if (v) begin
            if (m_dec == DECIM - 1) begin
                acc = 1'b1;
                m_dec = 0;
            end else begin
                m_dec++;
            end
        end
        was_idle = m_tx.size() == 0;
        if (m_tx.size() > 0 && !ff) void'(m_tx.pop_front());
        if (was_idle && m_coll.size() == SPF) begin
            build_frame();
            if (acc) m_coll.push_back(s);
        end else if (acc) begin
            if (m_coll.size() < SPF) m_coll.push_back(s);
            else drp = 1'b1;
        end
        if (clr) begin
            m_drops = 0;
            m_ovf = 1'b0;
        end else if (drp) begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
        end
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((m_tx.size() != 0 || m_coll.size() == SPF) && n < 200) begin
            step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
            n++;
        end
        check("drain_budget", 32'(n < 200), 32'd1);
    endtask

    task automatic feed(input int cnt, input logic [11:0] s4,
                        input logic [11:0] s8, input logic ff);
        for (int i = 1; i <= cnt; i++)
            step(1'b1, (i == 4) ? s4 : (i == 8) ? s8 : 12'($urandom),
                 1'b1, 1'b0, ff);
    endtask

    task automatic check_tail(input string tag, input logic [7:0] hi0,
                              input logic [7:0] lo0, input logic [7:0] hi1,
                              input logic [7:0] lo1);
        int n = wlog.size();
        check({tag, "_sync"}, 32'(wlog[n-7]), 32'h A5);
        check({tag, "_hi0"}, 32'(wlog[n-5]), 32'(hi0));
        check({tag, "_lo0"}, 32'(wlog[n-4]), 32'(lo0));
        check({tag, "_hi1"}, 32'(wlog[n-3]), 32'(hi1));
        check({tag, "_lo1"}, 32'(wlog[n-2]), 32'(lo1));
    endtask

    initial begin
        logic [7:0] exp_b [14];
        int n;
        exp_b = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'h94,
                  8'hA5, 8'h01, 8'h01, 8'hC7, 8'h02, 8'hF0, 8'h35};
        wpos = 0;
        rst = 1'b1;
        sample_i = '0;
        valid_i = 1'b0;
        enable_i = 1'b0;
        clear_i = 1'b0;
        fifo_full_i = 1'b0;
        model_reset();
        #2;
        check("rst_wr_en", 32'(wr_en_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        check("rst_drops", 32'(drop_count_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic frame
        feed(8, 12'h123, 12'hABC, 1'b0);
        drain();
        check("basic_len", 32'(wlog.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            check("basic_byte", 32'(wlog[i]), 32'(exp_b[i]));
        check("basic_busy_end", 32'(busy_o), 32'd0);

        // Backpressure during HI
        feed(8, 12'h1C7, 12'h2F0, 1'b0);
        n = 0;
        while (m_tx.size() != FLEN - 2 && n < 50) begin
            step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
            n++;
        end
        check("bp_reach_hi", 32'(n < 50), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 12'h000, 1'b1, 1'b0, 1'b1);
            check("bp_stall_wr", 32'(wr_en_o), 32'd0);
            check("bp_stall_data", 32'(data_o), 32'h01);
        end
        drain();
        check("bp_len", 32'(wlog.size()), 32'd14);
        for (int i = 7; i < 14; i++)
            check("bp_byte", 32'(wlog[i]), 32'(exp_b[i]));

        // Overflow with FIFO held full
        for (int i = 0; i < 24; i++)
            step(1'b1, 12'($urandom), 1'b1, 1'b0, 1'b1);
        check("ovf_count", 32'(drop_count_o), 32'd2);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        step(1'b0, 12'h000, 1'b1, 1'b1, 1'b1);
        check("clr_count", 32'(drop_count_o), 32'd0);
        check("clr_flag", 32'(overflow_o), 32'd0);
        drain();

        // Sample accepted in the swap cycle
        feed(8, 12'($urandom), 12'($urandom), 1'b0);
        feed(8, 12'($urandom), 12'($urandom), 1'b1);
        feed(3, 12'h000, 12'h000, 1'b1);
        n = 0;
        while (!(m_tx.size() == 0 && m_coll.size() == SPF) && n < 50) begin
            step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
            n++;
        end
        check("swap_reach", 32'(n < 50), 32'd1);
        step(1'b1, 12'h5E1, 1'b1, 1'b0, 1'b0);
        check("swap_no_drop", 32'(drop_count_o), 32'd0);
        feed(4, 12'h3D4, 12'h000, 1'b0);
        drain();
        check_tail("swap", 8'h05, 8'hE1, 8'h03, 8'hD4);
        check("swap_drops_end", 32'(drop_count_o), 32'd0);

        // Enable drop discards a partial buffer
        feed(4, 12'h777, 12'h000, 1'b0);
        step(1'b1, 12'($urandom), 1'b0, 1'b0, 1'b0);
        feed(8, 12'h4A2, 12'h0B3, 1'b0);
        drain();
        check_tail("enable", 8'h04, 8'hA2, 8'h00, 8'hB3);

        // Random traffic through the sequence wrap
        n = 0;
        while (seq_log.size() < 257 && n < 40000) begin
            step(($urandom_range(0, 3) != 0), 12'($urandom), 1'b1, 1'b0,
                 ($urandom_range(0, 4) == 0));
            n++;
        end
        check("wrap_budget", 32'(n < 40000), 32'd1);
        check("wrap_seq_ff", 32'(seq_log[255]), 32'hFF);
        check("wrap_seq_00", 32'(seq_log[256]), 32'h00);
        drain();

        // Reset in the middle of a LO byte
        feed(8, 12'($urandom), 12'($urandom), 1'b0);
        n = 0;
        while (m_tx.size() != FLEN - 3 && n < 50) begin
            step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
            n++;
        end
        check("rst_reach_lo", 32'(n < 50), 32'd1);
        check("rst_pre_wr", 32'(wr_en_o), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_wr", 32'(wr_en_o), 32'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_data", 32'(data_o), 32'd0);
        check("rst_mid_drops", 32'(drop_count_o), 32'd0);
        model_reset();
        seq_log.delete();
        wpos = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        feed(8, 12'($urandom), 12'($urandom), 1'b0);
        drain();
        check("rst_frames", 32'(seq_log.size()), 32'd1);
        check("rst_seq", 32'(seq_log[0]), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
